// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and receiver state encoding.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int unsigned c_clks_per_bit = 434;
    localparam int unsigned c_data_w       = 8;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_st_idle,
        ST_START = c_st_start,
        ST_DATA  = c_st_data,
        ST_STOP  = c_st_stop,
        ST_BREAK = c_st_break
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_sync_2ff
// Brief    : 1-bit two-flop synchronizer with parameterised reset value.
// Revision : 1.0
// ============================================================================
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, LSB first, mid-bit sampling, framing errors.
// Revision : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_clks_per_bit,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    output logic [c_data_w-1:0] data,
    output logic                valid,
    output logic                frame_err,
    output logic                busy
);

    localparam logic [CNT_W-1:0] c_half_cnt = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(CLKS_PER_BIT - 1);
    localparam int unsigned      c_idx_w    = $clog2(c_data_w);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_data_w - 1);

    rx_state_t           r_state,     w_next_state;
    logic [CNT_W-1:0]    r_cnt,       w_next_cnt;
    logic [c_idx_w-1:0]  r_bit_idx,   w_next_bit_idx;
    logic [c_data_w-1:0] r_shift,     w_next_shift;
    logic [c_data_w-1:0] r_data,      w_next_data;
    logic                r_valid,     w_next_valid;
    logic                r_frame_err, w_next_frame_err;
    logic                r_busy,      w_next_busy;
    logic                w_rx_s;

    uart_sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_bit_idx   <= w_next_bit_idx;
            r_shift     <= w_next_shift;
            r_data      <= w_next_data;
            r_valid     <= w_next_valid;
            r_frame_err <= w_next_frame_err;
            r_busy      <= w_next_busy;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt + 1'b1;
        w_next_bit_idx   = r_bit_idx;
        w_next_shift     = r_shift;
        w_next_data      = r_data;
        w_next_valid     = 1'b0;
        w_next_frame_err = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_cnt = '0;
                if (!w_rx_s) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is gone by its mid-point is a glitch.
                if (r_cnt == c_half_cnt) begin
                    w_next_cnt = '0;
                    if (!w_rx_s) begin
                        w_next_state   = ST_DATA;
                        w_next_bit_idx = '0;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (r_cnt == c_full_cnt) begin
                    w_next_cnt              = '0;
                    w_next_shift[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == c_last_idx) begin
                        w_next_state = ST_STOP;
                    end else begin
                        w_next_bit_idx = r_bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == c_full_cnt) begin
                    w_next_cnt = '0;
                    if (w_rx_s) begin
                        w_next_data  = r_shift;
                        w_next_valid = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_frame_err = 1'b1;
                        w_next_state     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here so a long low line reports only one error.
                w_next_cnt = '0;
                if (w_rx_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_cnt   = '0;
                w_next_state = ST_IDLE;
            end
        endcase

        w_next_busy = (w_next_state != ST_IDLE);
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 framing, LSB first, idle-high line.
- Downstream consumer of uart_tx. Samples the tx line, or an external RX pin, in the 50 MHz clk domain.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Baud set by CLKS_PER_BIT, which must match the uart_tx setting.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200). Legal range 8 to 65535.
- CNT_W, 16, width of the bit-period counter. Must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock, 50 MHz; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-cycle pulse: data has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; data unchanged.
- busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; data=8'h00; valid=0; frame_err=0; busy=0.
  - Both synchronizer flops=1; counters=0.
  - Reset mid-frame aborts the frame with no valid and no frame_err.
- Synchronizer: rx passes through 2 flops; rx_s is the second stage. All decisions use rx_s only.
- IDLE:
  - busy=0.
  - On rx_s==0: go to START, clear the bit counter, busy=1 from the next cycle.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer divide), then sample rx_s.
  - If 0: go to DATA, clear the counter, bit_idx=0.
  - If 1: treat as a glitch; go to IDLE with no flags.
- DATA:
  - Count to CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first), clear the counter.
  - After bit_idx==7 is sampled, go to STOP.
  - Each sample lands near mid-bit.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - If 1: data<=shift, valid=1 for exactly 1 cycle, go to IDLE.
  - If 0: frame_err=1 for exactly 1 cycle, data unchanged, go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE.
  - A held-low line or break produces exactly one frame_err, never repeated frames.
- Latency: valid/frame_err rise on the cycle after the stop-bit sample.
  - Start falling edge at the pin to valid ≈ 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
  - This is ±1 cycle for sync phase.
- Back-to-back frames: the next start bit may arrive immediately after the stop mid-point. IDLE detects it with no lost frame.
- valid and frame_err are never high together.
- busy is registered and high in START/DATA/STOP/BREAK.
- No receive FIFO. The consumer must take data before the next valid. A later good frame overwrites data silently.
- Counter arithmetic is unsigned CNT_W bits; no wrap-around occurs within legal parameters.

Decomposition:
- Shared package uart_pkg:
  - CLKS_PER_BIT default (434), shared with uart_tx.
  - Data width constant (8).
  - State encoding for IDLE/START/DATA/STOP/BREAK (3-bit localparams).
- One sub-module: uart_sync_2ff.
  - 1-bit, 2-flop synchronizer with reset value 1, parameterised reset value.
  - Reusable for other async pins.

Test Plan:
- Loopback with CLKS_PER_BIT=434: uart_tx sends 8'hA5, start pulsed 1 cycle after reset release. Required:
  - exactly one valid pulse ≈ 9.5*434 cycles after tx falls;
  - data==8'hA5; frame_err never high;
  - busy low again before 120 µs.
- Back-to-back frames, CLKS_PER_BIT=16: bench drives 8'h00, 8'hFF, 8'h55 with no idle gap. Required:
  - three valid pulses, data 8'h00, 8'hFF, 8'h55 in order.
- Glitch rejection: rx low for 3 cycles (< CLKS_PER_BIT/2=8) then high. Required:
  - return to IDLE; no valid, no frame_err;
  - busy high ≤ 10 cycles.
- Framing error: frame for 8'h3C with the stop bit driven 0, rx held low 40 cycles, then high. Required:
  - one frame_err pulse; data keeps its previous value;
  - no further pulses until the next good frame (8'h3C), which gives valid and data==8'h3C.
- Reset mid-frame: reset=0 for 2 cycles during DATA bit 4, then a full frame 8'hC3. Required:
  - outputs return to reset values with no flags;
  - the subsequent frame gives valid with data==8'hC3.
- Baud tolerance: frame for 8'h96 at +3% and -3% bit period, CLKS_PER_BIT=434. Required:
  - data==8'h96 and valid in both cases; no frame_err.
